// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C write engine: FSM encoding, quarter-phase codes
// and the R/W bit appended to the slave address.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_ADDR  = 3'd2,
        ST_ACK_A = 3'd3,
        ST_LOAD  = 3'd4,
        ST_DATA  = 3'd5,
        ST_ACK_D = 3'd6,
        ST_STOP  = 3'd7
    } state_t;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam logic W_BIT = 1'b0;

endpackage

// File: rtl/i2c_qtick.sv
// Quarter-bit timebase: counts 0..QDIV-1, ticks on the wrap and steps a 2-bit phase.
// Clear holds both the count and the phase at zero.
module i2c_qtick
    import i2c_pkg::*;
#(
    parameter int QDIV = 250
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clr,
    output logic       o_tick,
    output logic [1:0] o_phase
);

    localparam logic [15:0] QLAST = 16'(QDIV - 1);

    logic [15:0] r_cnt;
    logic [1:0]  r_phase;

    assign o_tick  = !i_clr && (r_cnt == QLAST);
    assign o_phase = r_phase;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_phase <= Q0;
        end else if (i_clr) begin
            r_cnt   <= '0;
            r_phase <= Q0;
        end else if (o_tick) begin
            r_cnt   <= '0;
            r_phase <= r_phase + 2'd1;
        end else begin
            r_cnt   <= r_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/i2c_write_engine.sv
// I2C master write sequencer: START, address+W, ACK, N host-supplied data bytes with ACK, STOP.
// Line controls are registered so SCL/SDA never glitch from decode logic.
//
//   state    | meaning
//   IDLE     | bus released, waiting for GO
//   START    | SCL high, SDA released then pulled low
//   ADDR     | shifting address + W bit, MSB first
//   ACK_A    | SDA released, slave ACK sampled at Q3 tick
//   LOAD     | SCL held low until the host offers a byte
//   DATA     | shifting data byte, MSB first
//   ACK_D    | SDA released, slave ACK sampled at Q3 tick
//   STOP     | SDA low under SCL low/high, then released
module i2c_write_engine
    import i2c_pkg::*;
#(
    parameter int QDIV = 250
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_go,
    input  logic [6:0] i_addr,
    input  logic [7:0] i_data_in,
    input  logic       i_data_valid,
    input  logic       i_data_last,
    output logic       o_data_ready,
    input  logic       i_sda_in,
    output logic       o_scl_out,
    output logic       o_sda_out,
    output logic       o_sda_oe,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_nack
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_shift;
    logic [2:0]  r_bit_cnt;
    logic        r_last;
    logic        r_nack;
    logic        r_done;
    logic        r_scl;
    logic        r_sda_out;
    logic        r_sda_oe;

    logic        w_tick;
    logic [1:0]  w_phase;
    logic        w_qclr;
    logic        w_bit_end;
    logic        w_go_acc;
    logic        w_accept;
    logic        w_shift_bit;
    logic        w_ack_fail;
    logic        w_stop_end;
    logic        w_scl;
    logic        w_sda_out;
    logic        w_sda_oe;

    // LOAD keeps the timebase cleared so the next data bit gets full-length quarters.
    assign w_qclr = (r_state == ST_IDLE) || (r_state == ST_LOAD);

    i2c_qtick #(.QDIV(QDIV)) u_qtick (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (w_qclr),
        .o_tick  (w_tick),
        .o_phase (w_phase)
    );

    assign w_bit_end   = w_tick && (w_phase == Q3);
    assign w_go_acc    = (r_state == ST_IDLE) && i_go;
    assign w_accept    = (r_state == ST_LOAD) && i_data_valid;
    assign w_shift_bit = ((r_state == ST_ADDR) || (r_state == ST_DATA)) && w_bit_end;
    assign w_ack_fail  = ((r_state == ST_ACK_A) || (r_state == ST_ACK_D)) && w_bit_end && i_sda_in;
    assign w_stop_end  = (r_state == ST_STOP) && w_bit_end;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (i_go)                             w_state_nxt = ST_START;
            ST_START: if (w_bit_end)                        w_state_nxt = ST_ADDR;
            ST_ADDR:  if (w_bit_end && r_bit_cnt == 3'd7)   w_state_nxt = ST_ACK_A;
            ST_ACK_A: if (w_bit_end)                        w_state_nxt = i_sda_in ? ST_STOP : ST_LOAD;
            ST_LOAD:  if (i_data_valid)                     w_state_nxt = ST_DATA;
            ST_DATA:  if (w_bit_end && r_bit_cnt == 3'd7)   w_state_nxt = ST_ACK_D;
            ST_ACK_D: if (w_bit_end)                        w_state_nxt = (i_sda_in || r_last) ? ST_STOP : ST_LOAD;
            ST_STOP:  if (w_bit_end)                        w_state_nxt = ST_IDLE;
            default:                                        w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_scl     = 1'b1;
        w_sda_out = 1'b1;
        w_sda_oe  = 1'b0;
        case (r_state)
            ST_START: begin
                if ((w_phase == Q2) || (w_phase == Q3)) begin
                    w_sda_oe  = 1'b1;
                    w_sda_out = 1'b0;
                end
            end
            ST_ADDR, ST_DATA: begin
                w_scl     = (w_phase == Q2) || (w_phase == Q3);
                w_sda_oe  = 1'b1;
                w_sda_out = r_shift[7];
            end
            ST_ACK_A, ST_ACK_D: begin
                w_scl = (w_phase == Q2) || (w_phase == Q3);
            end
            ST_LOAD: begin
                w_scl = 1'b0;
            end
            ST_STOP: begin
                case (w_phase)
                    Q0: begin
                        w_scl     = 1'b0;
                        w_sda_oe  = 1'b1;
                        w_sda_out = 1'b0;
                    end
                    Q1, Q2: begin
                        w_sda_oe  = 1'b1;
                        w_sda_out = 1'b0;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_last    <= 1'b0;
            r_nack    <= 1'b0;
            r_done    <= 1'b0;
            r_scl     <= 1'b1;
            r_sda_out <= 1'b1;
            r_sda_oe  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_done    <= w_stop_end;
            r_scl     <= w_scl;
            r_sda_out <= w_sda_out;
            r_sda_oe  <= w_sda_oe;

            if (w_go_acc) begin
                r_shift   <= {i_addr, W_BIT};
                r_bit_cnt <= '0;
                r_last    <= 1'b0;
                r_nack    <= 1'b0;
            end else if (w_accept) begin
                r_shift   <= i_data_in;
                r_last    <= i_data_last;
            end else if (w_shift_bit) begin
                r_shift   <= {r_shift[6:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end

            if (w_ack_fail) begin
                r_nack <= 1'b1;
            end
        end
    end

    assign o_data_ready = w_accept;
    assign o_scl_out    = r_scl;
    assign o_sda_out    = r_sda_out;
    assign o_sda_oe     = r_sda_oe;
    assign o_busy       = (r_state != ST_IDLE);
    assign o_done       = r_done;
    assign o_nack       = r_nack;

endmodule

// File: tb/tb_i2c_write_engine.sv
// Directed bench for i2c_write_engine: a bus monitor decodes START/bytes/ACK/STOP,
// acts as the slave, and checks SCL timing; the main sequence compares against hand-computed values.
module tb_i2c_write_engine;

    localparam int QDIV = 4;

    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic       go         = 1'b0;
    logic [6:0] addr       = '0;
    logic [7:0] data_in    = '0;
    logic       data_valid = 1'b0;
    logic       data_last  = 1'b0;
    logic       sda_in     = 1'b1;
    logic       data_ready;
    logic       scl_out;
    logic       sda_out;
    logic       sda_oe;
    logic       busy;
    logic       done;
    logic       nack;

    int n_vec  = 0;
    int n_miss = 0;

    logic       slv_nack_addr = 1'b0;
    logic [7:0] byte_q[$];
    logic       ack_q[$];
    int busy_total = 0, done_total = 0, rdy_total = 0;
    int start_total = 0, stop_total = 0;
    int long_lo_total = 0, long_lo_len = 0;
    int tmg_err = 0;

    int b0, st0, sp0, dn0, rd0, bz0, ll0;

    i2c_write_engine #(.QDIV(QDIV)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_go         (go),
        .i_addr       (addr),
        .i_data_in    (data_in),
        .i_data_valid (data_valid),
        .i_data_last  (data_last),
        .o_data_ready (data_ready),
        .i_sda_in     (sda_in),
        .o_scl_out    (scl_out),
        .o_sda_out    (sda_out),
        .o_sda_oe     (sda_oe),
        .o_busy       (busy),
        .o_done       (done),
        .o_nack       (nack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Bus monitor and slave: samples on the falling clock edge, releases/drives ACK on SCL falls.
    initial begin : mon
        logic       prev_scl, prev_sda, sda_bus, in_frame, short_pend;
        logic [8:0] shreg;
        int         bitpos, frame_byte, hi_len, lo_len;
        prev_scl = 1'b1; prev_sda = 1'b1; in_frame = 1'b0; short_pend = 1'b0;
        shreg = '0; bitpos = 0; frame_byte = 0; hi_len = 0; lo_len = 0;
        forever begin
            @(negedge clk);
            sda_bus = (sda_oe ? sda_out : 1'b1) & sda_in;
            if (rst) begin
                in_frame = 1'b0; short_pend = 1'b0; bitpos = 0; frame_byte = 0;
                hi_len = 0; lo_len = 0; sda_in = 1'b1;
            end else begin
                if (busy)       busy_total++;
                if (done)       done_total++;
                if (data_ready) rdy_total++;
                if (scl_out && prev_scl && (sda_bus != prev_sda)) begin
                    if (!sda_bus) begin
                        start_total++; in_frame = 1'b1; bitpos = 0; frame_byte = 0; shreg = '0;
                    end else begin
                        stop_total++; in_frame = 1'b0; short_pend = 1'b0;
                    end
                end
                if (scl_out && !prev_scl) begin
                    if (lo_len < QDIV) tmg_err++;
                    else if (lo_len < 2*QDIV) short_pend = 1'b1;
                    if (lo_len > 2*QDIV + 1) begin long_lo_total++; long_lo_len = lo_len; end
                    hi_len = 0;
                    if (in_frame) begin
                        shreg = {shreg[7:0], sda_bus};
                        bitpos++;
                        if (bitpos == 9) begin
                            byte_q.push_back(shreg[8:1]);
                            ack_q.push_back(shreg[0]);
                            bitpos = 0;
                            frame_byte++;
                        end
                    end
                end
                if (!scl_out && prev_scl) begin
                    if (hi_len < 2*QDIV) tmg_err++;
                    // only the low before a STOP may be a single quarter
                    if (short_pend) begin tmg_err++; short_pend = 1'b0; end
                    lo_len = 0;
                    sda_in = (in_frame && bitpos == 8) ? ((frame_byte == 0) ? slv_nack_addr : 1'b0) : 1'b1;
                end
                if (scl_out) hi_len++; else lo_len++;
            end
            prev_scl = scl_out;
            prev_sda = sda_bus;
        end
    end

    function automatic logic [31:0] bus_item(input int i);
        if (i < byte_q.size()) return {23'd0, ack_q[i], byte_q[i]};
        return 32'hFFFF_FFFF;
    endfunction

    task automatic snap();
        b0 = byte_q.size(); st0 = start_total; sp0 = stop_total; dn0 = done_total;
        rd0 = rdy_total; bz0 = busy_total; ll0 = long_lo_total;
    endtask

    task automatic do_go(input logic [6:0] a);
        @(negedge clk); addr = a; go = 1'b1;
        @(negedge clk); go = 1'b0;
    endtask

    task automatic feed_byte(input logic [7:0] d, input logic l, input int gap);
        int n;
        repeat (gap) @(posedge clk);
        #1; data_in = d; data_last = l; data_valid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!data_ready && n < 2000);
        chk("ready_seen", data_ready, 1);
        @(posedge clk); #1; data_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin @(negedge clk); n++; end
        chk("done_seen", done, 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_in_scl", scl_out, 1);
        chk("rst_in_oe", sda_oe, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_scl", scl_out, 1);
        chk("rst_sda_out", sda_out, 1);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_nack", nack, 0);
        chk("rst_ready", data_ready, 0);

        // one byte, acked: 80 quarters of bit time plus a single LOAD cycle = 321 busy cycles
        snap();
        do_go(7'h50);
        chk("t1_busy_on", busy, 1);
        feed_byte(8'hA5, 1'b1, 0);
        wait_done(2000);
        chk("t1_nbytes", byte_q.size() - b0, 2);
        chk("t1_addr", bus_item(b0), 32'h0A0);
        chk("t1_data", bus_item(b0 + 1), 32'h0A5);
        chk("t1_starts", start_total - st0, 1);
        chk("t1_stops", stop_total - sp0, 1);
        chk("t1_done_cnt", done_total - dn0, 1);
        chk("t1_ready_cnt", rdy_total - rd0, 1);
        chk("t1_busy_len", busy_total - bz0, 321);
        chk("t1_nack", nack, 0);

        // address NACK with DATA_VALID held high throughout: START+ADDR+ACK+STOP = 176 cycles
        slv_nack_addr = 1'b1;
        data_in = 8'hFF; data_last = 1'b0; data_valid = 1'b1;
        snap();
        do_go(7'h3C);
        wait_done(2000);
        data_valid = 1'b0;
        chk("t2_nbytes", byte_q.size() - b0, 1);
        chk("t2_addr", bus_item(b0), 32'h178);
        chk("t2_ready_cnt", rdy_total - rd0, 0);
        chk("t2_busy_len", busy_total - bz0, 176);
        chk("t2_stops", stop_total - sp0, 1);
        chk("t2_nack", nack, 1);
        repeat (20) @(negedge clk);
        chk("t2_nack_sticky", nack, 1);
        slv_nack_addr = 1'b0;

        // three bytes, second offered 10 cycles into its LOAD: 611 + 10 busy cycles, stretched low of 19
        snap();
        do_go(7'h22);
        chk("t3_nack_clr", nack, 0);
        feed_byte(8'h01, 1'b0, 0);
        feed_byte(8'h02, 1'b0, 36*QDIV + 10);
        feed_byte(8'h03, 1'b1, 0);
        wait_done(3000);
        chk("t3_nbytes", byte_q.size() - b0, 4);
        chk("t3_addr", bus_item(b0), 32'h044);
        chk("t3_b1", bus_item(b0 + 1), 32'h001);
        chk("t3_b2", bus_item(b0 + 2), 32'h002);
        chk("t3_b3", bus_item(b0 + 3), 32'h003);
        chk("t3_ready_cnt", rdy_total - rd0, 3);
        chk("t3_busy_len", busy_total - bz0, 621);
        chk("t3_stretch_cnt", long_lo_total - ll0, 1);
        chk("t3_stretch_len", long_lo_len, 19);
        chk("t3_done_cnt", done_total - dn0, 1);

        // reset in the middle of address bit 3
        snap();
        do_go(7'h7F);
        repeat (71) @(negedge clk);
        chk("t4_busy_pre", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("t4_scl", scl_out, 1);
        chk("t4_oe", sda_oe, 0);
        chk("t4_busy", busy, 0);
        chk("t4_sda_out", sda_out, 1);
        chk("t4_no_stop", stop_total - sp0, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // fresh run after reset, with a second GO (different address) while busy
        snap();
        do_go(7'h5A);
        repeat (40) @(negedge clk);
        addr = 7'h11; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        feed_byte(8'h3C, 1'b1, 0);
        wait_done(2000);
        chk("t5_nbytes", byte_q.size() - b0, 2);
        chk("t5_addr", bus_item(b0), 32'h0B4);
        chk("t5_data", bus_item(b0 + 1), 32'h03C);
        chk("t5_starts", start_total - st0, 1);
        chk("t5_done_cnt", done_total - dn0, 1);
        chk("t5_busy_len", busy_total - bz0, 321);
        chk("t5_ready_cnt", rdy_total - rd0, 1);

        chk("scl_timing_errs", tmg_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1);
    end

endmodule
